ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
Instruction fetch unit with a small prefetch queue. It is the requesting side of the instruction memory.
- Drives a word address to the combinational instruction memory.
- Captures the returned instruction in the same cycle and queues {pc, inst} pairs.
- Presents the queue head to decode through a valid/ready handshake.
- Sits between the PC/branch logic and the decode stage of the pipeline.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
fetch_en_i  input  1  enables fetching; 0 lets the queue drain with no new fetches
redirect_valid_i  input  1  branch/jump/trap redirect; flushes the queue
redirect_pc_i  input  32  new fetch address
imem_addr_o  output  32  byte address to instruction memory
imem_inst_i  input  32  instruction word; valid in the same cycle as imem_addr_o
if_valid_o  output  1  queue head valid
if_ready_i  input  1  decode accepts head
if_inst_o  output  32  head instruction
if_pc_o  output  32  head PC
level_o  output  log2(DEPTH)+1  occupied entries
misalign_o  output  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at a clock edge, takes priority over every other input):
  - fetch_pc=RESET_PC; state=IDLE; read/write pointers=0; level_o=0; misalign_o=0.
  - if_valid_o=0, if_inst_o=0, if_pc_o=0.
  - Reset mid-operation discards all queued entries.
- imem_addr_o = fetch_pc (registered value, combinational output). Memory is combinational, so there is zero-cycle fetch latency.
- FSM states: IDLE, RUN, FAULT (FAULT exists only with the macro).
  - IDLE -> RUN when fetch_en_i=1.
  - RUN -> IDLE when fetch_en_i=0.
  - Redirect does not change IDLE/RUN.
- Push condition: state==RUN, level_o<DEPTH, redirect_valid_i=0.
  - On push: write {fetch_pc, imem_inst_i} at the write pointer; fetch_pc += 4.
  - Addition is modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Pop condition: if_valid_o && if_ready_i && !redirect_valid_i. Read pointer advances.
- Full queue: no push, even if a pop happens in the same cycle. Throughput is therefore DEPTH words per DEPTH+1 cycles when full; this is accepted.
- Simultaneous push and pop when not full: level_o is unchanged.
- Pointers wrap modulo DEPTH.
- Output latency:
  - if_valid_o = (level_o != 0).
  - if_inst_o/if_pc_o are combinational reads of the head entry; they are 0 when empty.
  - An instruction fetched in cycle N is visible at the head in cycle N+1 at the earliest.
- Redirect (redirect_valid_i=1):
  - At the edge: pointers=0, level_o=0, fetch_pc=redirect_pc_i. No push and no pop that cycle.
  - The first new-path instruction is pushed the next cycle (if RUN) and is visible at the head 2 cycles after the redirect.
  - Redirect while empty or in IDLE still loads fetch_pc.
- fetch_en_i=0: state goes to IDLE, pushes stop, queued entries remain poppable, and fetch_pc holds.

Optional Feature:
Macro IFU_MISALIGN_CHK_EN.
- Defined, redirect with redirect_pc_i[1:0]!=0:
  - fetch_pc is loaded with the address, the queue is flushed, and state goes to FAULT.
  - misalign_o is registered and goes 1 the cycle after the redirect edge; it stays 1 while in FAULT.
  - No pushes occur in FAULT.
  - An aligned redirect exits to RUN if fetch_en_i=1, else IDLE, and clears misalign_o.
  - A misaligned redirect while in FAULT keeps the block in FAULT.
- Undefined:
  - redirect_pc_i[1:0] is forced to 00 on load.
  - FAULT is unreachable and misalign_o is tied to 0.

Test Plan:
- Reset, fetch_en_i=1, if_ready_i=1, memory word k = 32'h1000_0000+k → imem_addr_o sequence 0,4,8,...; first if_valid_o=1 one cycle after the first push with if_pc_o=0, if_inst_o=32'h1000_0000; one instruction per cycle thereafter.
- if_ready_i=0, DEPTH=4 → level_o saturates at 4, imem_addr_o holds 0x10. Raising if_ready_i for 1 cycle pops PC 0 with no push; the next cycle pushes PC 0x10.
- After 3 queued entries, redirect_pc_i=0x200 → next cycle level_o=0, if_valid_o=0, imem_addr_o=0x200. Two cycles after the redirect, if_pc_o=0x200.
- RESET_PC=0xFFFF_FFF8, run 3 fetches → queued PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- fetch_en_i dropped with 2 entries queued, if_ready_i=1 → both pop in order, then if_valid_o=0, imem_addr_o frozen. Asserting rst_i mid-stream → next cycle level_o=0, imem_addr_o=RESET_PC.
- With IFU_MISALIGN_CHK_EN, redirect to 0x102 → misalign_o=1 next cycle and no pushes for 5 cycles. Redirect to 0x100 → misalign_o=0 and fetching resumes at 0x100. Without the macro, redirect to 0x102 → imem_addr_o=0x100 and misalign_o stays 0.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a small {pc, inst} prefetch queue in front of decode.
// Optional misaligned-redirect fault state enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fetch_en_i,
   input  logic                     redirect_valid_i,
   input  logic [31:0]              redirect_pc_i,
   output logic [31:0]              imem_addr_o,
   input  logic [31:0]              imem_inst_i,
   output logic                     if_valid_o,
   input  logic                     if_ready_i,
   output logic [31:0]              if_inst_o,
   output logic [31:0]              if_pc_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     misalign_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FAULT = 2'd2;

   logic [1:0]       state, state_next;
   logic [31:0]      fetch_pc, fetch_pc_next;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
   logic [LVL_W-1:0] level, level_next;
   logic             push, pop;

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];

   // Next-state, pointer and fetch-address logic
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      rd_ptr_next   = rd_ptr;
      wr_ptr_next   = wr_ptr;
      level_next    = level;
      push          = 1'b0;
      pop           = 1'b0;

      case (state)
         IDLE:    if (fetch_en_i) state_next = RUN;
         RUN:     if (!fetch_en_i) state_next = IDLE;
         FAULT:   state_next = state;
         default: state_next = IDLE;
      endcase

      if (redirect_valid_i) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         level_next  = '0;
`ifdef IFU_MISALIGN_CHK_EN
         fetch_pc_next = redirect_pc_i;
         if (redirect_pc_i[1:0] != 2'b00)
            state_next = FAULT;
         else if (state == FAULT)
            state_next = fetch_en_i ? RUN : IDLE;
`else
         fetch_pc_next = redirect_pc_i & 32'hFFFF_FFFC;
`endif
      end else begin
         // A full queue never pushes, even when the head pops this cycle
         push = (state == RUN) && (level < LVL_W'(DEPTH));
         pop  = (level != '0) && if_ready_i;
         if (push) begin
            wr_ptr_next   = wr_ptr + PTR_W'(1);
            fetch_pc_next = fetch_pc + 32'd4;
         end
         if (pop)
            rd_ptr_next = rd_ptr + PTR_W'(1);
         if (push && !pop)
            level_next = level + LVL_W'(1);
         else if (pop && !push)
            level_next = level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         rd_ptr   <= rd_ptr_next;
         wr_ptr   <= wr_ptr_next;
         level    <= level_next;
      end
   end

   // Queue storage; emptiness is tracked by level, so no reset is needed here
   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         inst_mem[wr_ptr] <= imem_inst_i;
      end
   end

`ifdef IFU_MISALIGN_CHK_EN
   logic misalign;

   always_ff @(posedge clk_i) begin
      if (rst_i) misalign <= 1'b0;
      else       misalign <= (state_next == FAULT);
   end

   assign misalign_o = misalign;
`else
   assign misalign_o = 1'b0;
`endif

   assign imem_addr_o = fetch_pc;
   assign level_o     = level;
   assign if_valid_o  = (level != '0);
   assign if_pc_o     = if_valid_o ? pc_mem[rd_ptr]   : 32'h0;
   assign if_inst_o   = if_valid_o ? inst_mem[rd_ptr] : 32'h0;

endmodule
